// File: rtl/p2s_serializer.sv
// Parallel-to-serial upstream stage: takes a word on load/ready, shifts it into the
// FIFO serial write port one bit per cycle, optional parity bit, stalls on full, abort flushes.
module p2s_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned PARITY    = 0
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [WIDTH-1:0] word_in,
    input  logic             load,
    input  logic             abort,
    input  logic             full,
    output logic             ready,
    output logic             dataIn,
    output logic             insert,
    output logic             flush,
    output logic             busy,
    output logic [15:0]      words_sent,
    output logic [1:0]       state_o
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               par_q, par_d;
    logic               flush_q, flush_d;
    logic [15:0]        words_q, words_d;

    logic               head_bit;
    logic               parity_bit;
    logic [WIDTH-1:0]   shift_adv;
    logic               last_bit;

    // Handshake: a word is taken on any edge with load && ready; ready is purely
    // state-derived (high only in IDLE) so it never depends on load in the same cycle.
    assign ready      = (state_q == ST_IDLE);
    assign busy       = ~ready;
    assign flush      = flush_q;
    assign words_sent = words_q;
    assign state_o    = state_q;

    assign head_bit   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign parity_bit = (PARITY == 2) ? ~par_q : par_q;
    assign shift_adv  = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
    assign last_bit   = (cnt_q == CNT_W'(WIDTH - 1));

    // Write strobe is gated by full in the same cycle so the FIFO is never overrun.
    assign insert = ((state_q == ST_SHIFT) || (state_q == ST_PARITY)) && !full && !abort;

    always_comb begin
        dataIn = 1'b0;
        case (state_q)
            ST_SHIFT:  dataIn = head_bit;
            ST_PARITY: dataIn = parity_bit;
            default:   dataIn = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        words_d = words_q;
        flush_d = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            shift_d = '0;
            cnt_d   = '0;
            flush_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        state_d = ST_SHIFT;
                        shift_d = word_in;
                        cnt_d   = '0;
                        par_d   = ^word_in;
                    end
                end
                ST_SHIFT: begin
                    if (insert) begin
                        shift_d = shift_adv;
                        if (last_bit) begin
                            cnt_d = '0;
                            if (PARITY != 0) begin
                                state_d = ST_PARITY;
                            end else begin
                                state_d = ST_IDLE;
                                words_d = words_q + 16'd1;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (insert) begin
                        state_d = ST_IDLE;
                        words_d = words_q + 16'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            flush_q <= 1'b0;
            words_q <= 16'd0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            flush_q <= flush_d;
            words_q <= words_d;
        end
    end

endmodule

// File: tb/tb_p2s_serializer.sv
// Bench for p2s_serializer: three configurations (plain, even parity MSB-first,
// odd parity LSB-first) driven one at a time; a monitor checks the serial stream.
module tb_p2s_serializer;

    localparam int W     = 8;
    localparam int N_DUT = 3;
    localparam int MSB_C [N_DUT] = '{1, 1, 0};
    localparam int PAR_C [N_DUT] = '{0, 1, 2};

    logic         clk_in = 1'b0;
    logic         rst;
    logic [W-1:0] word_s   [N_DUT];
    logic         load_s   [N_DUT];
    logic         abort_s  [N_DUT];
    logic         full_s   [N_DUT];
    logic         ready_s  [N_DUT];
    logic         data_s   [N_DUT];
    logic         insert_s [N_DUT];
    logic         flush_s  [N_DUT];
    logic         busy_s   [N_DUT];
    logic [15:0]  words_s  [N_DUT];
    logic [1:0]   state_s  [N_DUT];

    logic [15:0]  words_exp [N_DUT];
    logic [0:0]   exp_q [$];
    int           n_checks = 0;
    int           n_errors = 0;

    p2s_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .PARITY(0)) u_dut0 (
        .clk_in(clk_in), .rst(rst), .word_in(word_s[0]), .load(load_s[0]),
        .abort(abort_s[0]), .full(full_s[0]), .ready(ready_s[0]), .dataIn(data_s[0]),
        .insert(insert_s[0]), .flush(flush_s[0]), .busy(busy_s[0]),
        .words_sent(words_s[0]), .state_o(state_s[0])
    );

    p2s_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .PARITY(1)) u_dut1 (
        .clk_in(clk_in), .rst(rst), .word_in(word_s[1]), .load(load_s[1]),
        .abort(abort_s[1]), .full(full_s[1]), .ready(ready_s[1]), .dataIn(data_s[1]),
        .insert(insert_s[1]), .flush(flush_s[1]), .busy(busy_s[1]),
        .words_sent(words_s[1]), .state_o(state_s[1])
    );

    p2s_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .PARITY(2)) u_dut2 (
        .clk_in(clk_in), .rst(rst), .word_in(word_s[2]), .load(load_s[2]),
        .abort(abort_s[2]), .full(full_s[2]), .ready(ready_s[2]), .dataIn(data_s[2]),
        .insert(insert_s[2]), .flush(flush_s[2]), .busy(busy_s[2]),
        .words_sent(words_s[2]), .state_o(state_s[2])
    );

    // Clock / watchdog
    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int nbits_of(input int idx);
        return W + ((PAR_C[idx] != 0) ? 1 : 0);
    endfunction

    // Reference stream: data bits in the configured order, then parity of the whole word.
    function automatic void push_bits(input int idx, input logic [W-1:0] w, input int n);
        logic [W:0] stream;
        for (int k = 0; k < W; k++)
            stream[k] = (MSB_C[idx] != 0) ? w[W-1-k] : w[k];
        stream[W] = (PAR_C[idx] == 2) ? ~(^w) : (^w);
        for (int k = 0; k < n; k++)
            exp_q.push_back(stream[k]);
    endfunction

    // Monitor: every write strobe pops one expected bit
    always begin
        @(negedge clk_in);
        #2;
        for (int i = 0; i < N_DUT; i++) begin
            if (insert_s[i]) begin
                check("write_while_full", full_s[i], 1'b0);
                if (exp_q.size() == 0) begin
                    check("stream_extra_bit", 32'd1, 32'd0);
                end else begin
                    check("stream_bit", data_s[i], exp_q.pop_front());
                end
            end
        end
    end

    // Driver tasks
    task automatic wait_ready(input int idx);
        int t = 0;
        while (1) begin
            @(negedge clk_in);
            #1;
            if (ready_s[idx]) break;
            t++;
            if (t > 50) begin
                check("ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic check_reset_outputs();
        for (int i = 0; i < N_DUT; i++) begin
            check("rst_ready", ready_s[i], 1'b1);
            check("rst_busy", busy_s[i], 1'b0);
            check("rst_insert", insert_s[i], 1'b0);
            check("rst_dataIn", data_s[i], 1'b0);
            check("rst_flush", flush_s[i], 1'b0);
            check("rst_words", words_s[i], 16'd0);
            check("rst_state", state_s[i], 2'd0);
        end
    endtask

    // mode 0: no stall, 1: random stalls, 2: full during cycles T+3..T+5
    task automatic run_word(input int idx, input logic [W-1:0] w, input int mode);
        int  busy_cnt = 0;
        int  stall_cnt = 0;
        int  c = 0;
        bit  done = 0;
        wait_ready(idx);
        word_s[idx] = w;
        load_s[idx] = 1'b1;
        push_bits(idx, w, nbits_of(idx));
        @(posedge clk_in);
        while (!done) begin
            @(negedge clk_in);
            load_s[idx] = 1'b0;
            c++;
            case (mode)
                1:       full_s[idx] = ($urandom_range(0, 99) < 30);
                2:       full_s[idx] = (c >= 3 && c <= 5);
                default: full_s[idx] = 1'b0;
            endcase
            #1;
            if (ready_s[idx]) begin
                done = 1;
            end else begin
                busy_cnt++;
                if (full_s[idx]) stall_cnt++;
                check("insert_vs_full", insert_s[idx], !full_s[idx]);
                check("busy_flag", busy_s[idx], 1'b1);
                check("flush_quiet", flush_s[idx], 1'b0);
                if (c > 100) begin
                    check("word_timeout", 32'd0, 32'd1);
                    done = 1;
                end
            end
        end
        full_s[idx] = 1'b0;
        check("busy_cycles", busy_cnt, nbits_of(idx) + stall_cnt);
        words_exp[idx] = words_exp[idx] + 16'd1;
        check("words_sent", words_s[idx], words_exp[idx]);
    endtask

    task automatic abort_word(input int idx, input logic [W-1:0] w);
        wait_ready(idx);
        word_s[idx] = w;
        load_s[idx] = 1'b1;
        push_bits(idx, w, 3);
        @(posedge clk_in);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            load_s[idx] = 1'b0;
            #1;
            check("abort_pre_insert", insert_s[idx], 1'b1);
        end
        @(negedge clk_in);
        abort_s[idx] = 1'b1;
        #1;
        check("abort_cycle_insert", insert_s[idx], 1'b0);
        check("abort_cycle_busy", busy_s[idx], 1'b1);
        @(negedge clk_in);
        abort_s[idx] = 1'b0;
        #1;
        check("abort_flush_pulse", flush_s[idx], 1'b1);
        check("abort_ready", ready_s[idx], 1'b1);
        check("abort_insert_after", insert_s[idx], 1'b0);
        check("abort_words", words_s[idx], words_exp[idx]);
        @(negedge clk_in);
        #1;
        check("abort_flush_end", flush_s[idx], 1'b0);
    endtask

    task automatic abort_load_idle(input int idx);
        wait_ready(idx);
        word_s[idx]  = W'($urandom_range(0, 255));
        load_s[idx]  = 1'b1;
        abort_s[idx] = 1'b1;
        @(negedge clk_in);
        load_s[idx]  = 1'b0;
        abort_s[idx] = 1'b0;
        #1;
        check("idle_abort_flush", flush_s[idx], 1'b1);
        check("idle_abort_ready", ready_s[idx], 1'b1);
        check("idle_abort_insert", insert_s[idx], 1'b0);
        @(negedge clk_in);
        #1;
        check("idle_abort_flush_end", flush_s[idx], 1'b0);
        check("idle_abort_still_idle", ready_s[idx], 1'b1);
    endtask

    task automatic reset_mid_word(input int idx, input logic [W-1:0] w);
        wait_ready(idx);
        word_s[idx] = w;
        load_s[idx] = 1'b1;
        push_bits(idx, w, 4);
        @(posedge clk_in);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            load_s[idx] = 1'b0;
        end
        @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        for (int i = 0; i < N_DUT; i++) words_exp[i] = 16'd0;
        #1;
        check_reset_outputs();
        @(negedge clk_in);
        #1;
        check("rst_no_flush", flush_s[idx], 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < N_DUT; i++) begin
            word_s[i]    = '0;
            load_s[i]    = 1'b0;
            abort_s[i]   = 1'b0;
            full_s[i]    = 1'b0;
            words_exp[i] = 16'd0;
        end
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        #1;
        check_reset_outputs();

        run_word(0, 8'hA5, 0);
        run_word(1, 8'h07, 0);
        run_word(2, 8'h07, 0);
        run_word(2, 8'h01, 0);
        run_word(0, 8'hF0, 2);
        run_word(1, 8'hF0, 2);

        abort_word(0, 8'h3C);
        abort_load_idle(0);
        abort_word(1, 8'hC3);
        abort_load_idle(2);
        run_word(0, 8'h81, 0);

        reset_mid_word(1, 8'h5A);

        // Counter wrap: preload 0xFFFF while idle, then send one more word
        @(negedge clk_in);
        force u_dut0.words_q = 16'hFFFF;
        #1;
        release u_dut0.words_q;
        words_exp[0] = 16'hFFFF;
        run_word(0, W'($urandom_range(0, 255)), 0);

        for (int n = 0; n < 45; n++)
            run_word(int'($urandom_range(0, N_DUT - 1)), W'($urandom_range(0, 255)), 1);

        repeat (3) @(negedge clk_in);
        check("stream_leftover", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/p2s_serializer.md
# p2s_serializer

Upstream stage of the parallel-to-serial interface, in the write (`clk_in`) domain. It accepts a parallel word through a ready/load handshake and emits it one bit per cycle into the FIFO's serial write port (`dataIn`/`insert`). It can append a parity bit and stalls on FIFO `full`. It can also abort a word in progress and drive the FIFO `flush` input.

## Interface
- `WIDTH`, default 8: parallel word width, ≥2.
- `MSB_FIRST`, default 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- `PARITY`, default 0: 0 = none; 1 = even parity bit appended; 2 = odd parity bit appended.
- `clk_in`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `word_in`  in  WIDTH  parallel word, sampled on accept.
- `load`  in  1  word valid; accepted when `load && ready` at a clock edge.
- `abort`  in  1  cancels the current word and requests a FIFO flush.
- `full`  in  1  FIFO full flag.
- `ready`  out  1  high only in IDLE; the block can accept a word.
- `dataIn`  out  1  serial bit to the FIFO.
- `insert`  out  1  FIFO write strobe.
- `flush`  out  1  one-cycle flush pulse to the FIFO.
- `busy`  out  1  equals `!ready`.
- `words_sent`  out  16  count of fully serialized words; wraps.

## Operation
- FSM states:
  - IDLE -> SHIFT on accept.
  - SHIFT -> PARITY after the last data bit is written, if `PARITY != 0`.
  - SHIFT -> IDLE after the last data bit is written, if `PARITY == 0`.
  - PARITY -> IDLE after the parity bit is written.
  - Any state -> IDLE on `abort`.
- On accept:
  - The shift register loads `word_in`.
  - The bit counter is cleared.
  - The parity accumulator is set to XOR-reduce(`word_in`). Even parity bit = XOR; odd parity bit = ~XOR.
- `insert` is combinational: `insert = (state==SHIFT || state==PARITY) && !full && !abort`.
  - Because it is gated by `full` in the same cycle, no write is ever issued while the FIFO is full.
- `dataIn`:
  - In SHIFT: the current head bit of the shift register (MSB or LSB per `MSB_FIRST`).
  - In PARITY: the parity bit.
  - Otherwise: 0.
- On each edge where `insert` is high:
  - The shift register advances by one.
  - The bit counter increments. The counter is $clog2(WIDTH) bits wide and compares against WIDTH-1 for the last bit.
- Stall: while `full` is high, the state, shift register and counter all hold, and `dataIn` holds its value.
- `words_sent` increments on the edge that writes the final bit of a word:
  - the last data bit if `PARITY == 0`;
  - otherwise the parity bit.
  - 16-bit wrap: 0xFFFF -> 0x0000.
- Abort:
  - `abort` high at an edge forces IDLE and clears the shift register and counter.
  - `flush` is registered high for exactly the next cycle.
  - The aborted word is not counted.
  - In IDLE, `abort` together with `load`: abort wins and the word is not accepted.
  - Abort in IDLE still produces the flush pulse.
- `ready` must not depend combinationally on `load`.

## Timing
- Reset (synchronous, `rst` high at an edge): state IDLE, `ready`=1, `busy`=0, `insert`=0, `dataIn`=0, `flush`=0, `words_sent`=0, shift register=0, counter=0.
- Reset has priority over `abort` and `load`.
- Reset mid-word discards the word and does not pulse `flush`.
- Accept at edge T:
  - `insert` is high in cycles T+1 … T+WIDTH, one bit each, with no stall.
  - The parity bit (if enabled) is in cycle T+WIDTH+1.
  - `ready` returns high in the cycle after the final bit's write edge.
  - Minimum period per word is WIDTH+1 cycles (no parity) or WIDTH+2 cycles (with parity).
- Each stall cycle adds exactly one cycle of latency; bit order and values are unchanged.
- `flush` is high in cycle T+1 for an abort sampled at edge T.
- `insert` is low in the abort cycle itself.

## Test plan
- Reset, then `WIDTH`=8, `MSB_FIRST`=1, `PARITY`=0, `word_in`=0xA5 accepted at T, `full`=0 -> `dataIn`=1,0,1,0,0,1,0,1 with `insert` high in T+1..T+8; `words_sent`=1; `ready` high at T+9.
- `PARITY`=1, `word_in`=0x07 -> 8 data bits followed by parity bit 1 in cycle 9. `PARITY`=2, same word -> parity bit 0. `MSB_FIRST`=0, word 0x01 -> first bit 1, then seven 0s.
- Word 0xF0 with `full` high during cycles T+3..T+5 -> `insert` low in those cycles; the bit stream is still 1,1,1,1,0,0,0,0, completing at T+11.
- `abort` at the 4th bit -> `flush` is a 1-cycle pulse, `insert` low, `ready` high the next cycle, `words_sent` unchanged. `abort` with `load` in IDLE -> flush pulse and no accept.
- `rst` mid-word -> all outputs at reset values the next cycle, no `flush`. Preload `words_sent`=0xFFFF via 65535 words (or a forced state), send one more word -> `words_sent`=0x0000.
- Random words and random `full` stalls against a scoreboard -> the serial stream matches the words in order, and `insert` is never high while `full` is high.
